// File: rtl/mem_1r1w_banked.sv
// mem_1r1w_banked: single-clock 1-read/1-write memory assembled from
// power-of-two banks. Per-lane write masking, post-reset hardware clear with
// a done flag, out-of-range protection on both ports.
// Optional read-during-write forwarding is built when the macro
// MEM_1R1W_BANKED_BYPASS_EN is defined; otherwise a same-address read and
// write in one cycle returns the old contents (read-before-write).
//
// Handshake: there is no back-pressure. A read is accepted in any cycle where
// init_done=1 and R0_en=1; its data appears on R0_data after the next rising
// edge and is held until the next accepted read. A write is accepted in any
// cycle where init_done=1 and W0_en=1, and is dropped if W0_addr >= DEPTH.
module mem_1r1w_banked #(
  parameter int DEPTH      = 48,
  parameter int WIDTH      = 64,
  parameter int BANK_DEPTH = 32,
  parameter int MASK_GRAN  = 16,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LANES     = WIDTH / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [LANES-1:0]  W0_mask,
  output logic              o_dbg_state
);

  localparam int ROW_W  = $clog2(BANK_DEPTH);
  localparam int NBANKS = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  // Address is widened so the bank field exists even when DEPTH < BANK_DEPTH.
  localparam int AW_EXT = (ADDR_W > ROW_W) ? ADDR_W : ROW_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ROW_W-1:0]  LAST_ROW_C = ROW_W'(BANK_DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ROW_W-1:0] r_clr_row;
  logic [ROW_W-1:0] w_clr_row_next;
  logic             w_ready;
  logic             w_clearing;

  // ---------------------------------------------------------------------------
  // Init FSM: sweep every row of every bank to zero, then serve traffic.
  // ---------------------------------------------------------------------------

  // State and clear-row registers; reset always restarts the sweep at row 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_row <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_row <= w_clr_row_next;
    end
  end

  // Next-state logic: advance one row per cycle, leave CLEAR after the last row.
  always_comb begin
    w_state_next   = r_state;
    w_clr_row_next = r_clr_row;
    case (r_state)
      ST_CLEAR: begin
        w_clr_row_next = r_clr_row + ROW_W'(1);
        if (r_clr_row == LAST_ROW_C) begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        w_state_next = ST_READY;
      end
      default: begin
        w_state_next = ST_CLEAR;
      end
    endcase
  end

  assign w_ready     = (r_state == ST_READY);
  assign w_clearing  = (r_state == ST_CLEAR);
  assign init_done   = w_ready;
  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [AW_EXT-1:0] w_r_addr_ext;
  logic [AW_EXT-1:0] w_w_addr_ext;
  logic [ROW_W-1:0]  w_r_row;
  logic [ROW_W-1:0]  w_w_row;
  logic [BANK_W-1:0] w_r_bank;
  logic [BANK_W-1:0] w_w_bank;
  logic              w_r_in_range;
  logic              w_w_in_range;
  logic              w_rd_fire;
  logic              w_wr_fire;

  assign w_r_addr_ext = AW_EXT'(R0_addr);
  assign w_w_addr_ext = AW_EXT'(W0_addr);
  assign w_r_row      = w_r_addr_ext[ROW_W-1:0];
  assign w_w_row      = w_w_addr_ext[ROW_W-1:0];
  assign w_r_bank     = BANK_W'(w_r_addr_ext >> ROW_W);
  assign w_w_bank     = BANK_W'(w_w_addr_ext >> ROW_W);
  assign w_r_in_range = ({1'b0, R0_addr} < DEPTH_C);
  assign w_w_in_range = ({1'b0, W0_addr} < DEPTH_C);

  // Both ports are dead while clearing; a write racing a reset edge is dropped.
  assign w_rd_fire = w_ready & R0_en;
  assign w_wr_fire = w_ready & ~reset & W0_en & w_w_in_range;

  // ---------------------------------------------------------------------------
  // Banks: storage plus one registered read port each
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_bank_q [NBANKS];

  for (genvar gb = 0; gb < NBANKS; gb++) begin : g_bank
    logic [WIDTH-1:0] r_mem [BANK_DEPTH];
    logic [WIDTH-1:0] r_rd_q;

    // Storage: clear sweep has priority, otherwise masked per-lane write.
    always_ff @(posedge clock) begin
      if (w_clearing) begin
        r_mem[r_clr_row] <= '0;
      end else if (w_wr_fire && (w_w_bank == BANK_W'(gb))) begin
        for (int l = 0; l < LANES; l++) begin
          if (W0_mask[l]) begin
            r_mem[w_w_row][l*MASK_GRAN +: MASK_GRAN] <= W0_data[l*MASK_GRAN +: MASK_GRAN];
          end
        end
      end
    end

    // Read register: only the addressed bank loads, every other bank holds.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_rd_q <= '0;
      end else if (w_rd_fire && (w_r_bank == BANK_W'(gb))) begin
        r_rd_q <= r_mem[w_r_row];
      end
    end

    assign w_bank_q[gb] = r_rd_q;
  end

  // ---------------------------------------------------------------------------
  // Read-side selection
  // ---------------------------------------------------------------------------
  logic [BANK_W-1:0] r_bank_idx;
  logic              r_in_range;
  logic [WIDTH-1:0]  w_mux;
  logic [WIDTH-1:0]  w_merged;

  // Bank index and range flag of the last accepted read steer the output mux.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bank_idx <= '0;
      r_in_range <= 1'b0;
    end else if (w_rd_fire) begin
      r_bank_idx <= w_r_bank;
      r_in_range <= w_r_in_range;
    end
  end

  // Bank output mux; an index past the last bank yields zero.
  always_comb begin
    w_mux = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (r_bank_idx == BANK_W'(b)) begin
        w_mux = w_bank_q[b];
      end
    end
  end

`ifdef MEM_1R1W_BANKED_BYPASS_EN
  logic [LANES-1:0] r_fwd_mask;
  logic [WIDTH-1:0] r_fwd_data;
  logic             w_collide;

  assign w_collide = w_rd_fire & w_wr_fire & w_r_in_range & (R0_addr == W0_addr);

  // Forward register: remembers which lanes of the read were overwritten this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else if (w_rd_fire) begin
      r_fwd_mask <= w_collide ? W0_mask : '0;
      r_fwd_data <= W0_data;
    end
  end

  // Lane merge after the bank mux: forwarded lanes replace the stale bank data.
  always_comb begin
    w_merged = w_mux;
    for (int l = 0; l < LANES; l++) begin
      if (r_fwd_mask[l]) begin
        w_merged[l*MASK_GRAN +: MASK_GRAN] = r_fwd_data[l*MASK_GRAN +: MASK_GRAN];
      end
    end
  end
`else
  assign w_merged = w_mux;
`endif

  assign R0_data = r_in_range ? w_merged : '0;

endmodule

// File: tb/tb_mem_1r1w_banked.sv
// Testbench for mem_1r1w_banked with default parameters (DEPTH=48, WIDTH=64,
// BANK_DEPTH=32, MASK_GRAN=16). Build with MEM_1R1W_BANKED_BYPASS_EN defined
// to exercise the forwarding variant.
module tb_mem_1r1w_banked;

  localparam int DEPTH = 48;
  localparam int AW    = 6;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init_done;
  logic [AW-1:0] R0_addr = '0;
  logic        R0_en = 1'b0;
  logic [63:0] R0_data;
  logic [AW-1:0] W0_addr = '0;
  logic        W0_en = 1'b0;
  logic [63:0] W0_data = '0;
  logic [3:0]  W0_mask = '0;
  logic        o_dbg_state;

  always #5 clock = ~clock;

  mem_1r1w_banked dut (
    .clock      (clock),
    .reset      (reset),
    .init_done  (init_done),
    .R0_addr    (R0_addr),
    .R0_en      (R0_en),
    .R0_data    (R0_data),
    .W0_addr    (W0_addr),
    .W0_en      (W0_en),
    .W0_data    (W0_data),
    .W0_mask    (W0_mask),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic [63:0] model [64];
  bit          model_ready;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [63:0] lane_bits(input logic [3:0] m);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = {16{m[l]}};
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = '0;
    model_ready = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drives one cycle of traffic, pushes the expected
  // read result, updates the model, and returns at the next falling edge with
  // the read result (if any) visible on R0_data.
  task automatic drive_cycle(input logic rd, input logic [AW-1:0] raddr,
                             input logic wr, input logic [AW-1:0] waddr,
                             input logic [63:0] wdata, input logic [3:0] wmask);
    logic [63:0] exp;
    logic [63:0] lm;
    lm      = lane_bits(wmask);
    R0_en   = rd;
    R0_addr = raddr;
    W0_en   = wr;
    W0_addr = waddr;
    W0_data = wdata;
    W0_mask = wmask;
    if (rd && model_ready) begin
      exp = (raddr < DEPTH) ? model[raddr] : 64'h0;
`ifdef MEM_1R1W_BANKED_BYPASS_EN
      if (wr && (raddr == waddr) && (raddr < DEPTH)) exp = (exp & ~lm) | (wdata & lm);
`endif
      exp_q.push_back(exp);
    end
    if (wr && model_ready && (waddr < DEPTH)) model[waddr] = (model[waddr] & ~lm) | (wdata & lm);
    @(posedge clock);
    @(negedge clock);
    R0_en = 1'b0;
    W0_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [63:0] exp;
    model_clear();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (init_done !== 1'b0 || R0_data !== 64'h0 || o_dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: init_done=%b R0_data=%h state=%b, required 0/0/0",
               init_done, R0_data, o_dbg_state);
    end
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (init_done !== 1'b0) begin
        n_errors++;
        $display("FAIL clear_init_done cycle %0d: got %b, required 0", k, init_done);
      end
      n_checks++;
      if (R0_data !== 64'h0) begin
        n_errors++;
        $display("FAIL clear_rdata cycle %0d: got %h, required 0", k, R0_data);
      end
      drive_cycle(1'b1, AW'($urandom_range(0, 47)), 1'b1, AW'($urandom_range(0, 47)),
                  {$urandom, $urandom} | 64'h1, 4'hF);
    end
    n_checks++;
    if (init_done !== 1'b1 || o_dbg_state !== 1'b1) begin
      n_errors++;
      $display("FAIL init_done_rise: init_done=%b state=%b, required 1/1", init_done, o_dbg_state);
    end
    model_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b1, AW'(a), 1'b0, '0, '0, '0);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL clear_read addr %0d: no expected entry", a);
      end else begin
        exp = exp_q.pop_front();
        if (R0_data !== exp) begin
          n_errors++;
          $display("FAIL clear_read addr %0d: got %h, required %h", a, R0_data, exp);
        end
      end
    end
  endtask

  task automatic test_bank_boundary_mask();
    logic [63:0] exp;
    logic [AW-1:0] addrs [6] = '{6'd31, 6'd32, 6'd0, 6'd47, 6'd32, 6'd32};
    logic [63:0]   lits  [6] = '{64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0,
                                 64'h0, 64'hAAAA_FFFF_CCCC_FFFF, 64'hAAAA_FFFF_CCCC_FFFF};
    drive_cycle(1'b0, '0, 1'b1, 6'd31, 64'h1111_2222_3333_4444, 4'hF);
    drive_cycle(1'b0, '0, 1'b1, 6'd32, 64'hAAAA_BBBB_CCCC_DDDD, 4'hF);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) drive_cycle(1'b0, '0, 1'b1, 6'd32, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0101);
      if (i == 5) drive_cycle(1'b0, '0, 1'b1, 6'd32, 64'h0, 4'b0000);
      drive_cycle(1'b1, addrs[i], 1'b0, '0, '0, '0);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL boundary_read %0d: no expected entry", i);
      end else begin
        exp = exp_q.pop_front();
        if (R0_data !== exp || R0_data !== lits[i]) begin
          n_errors++;
          $display("FAIL boundary_read %0d addr %0d: got %h, required %h", i, addrs[i], R0_data, lits[i]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] exp;
    logic [AW-1:0] addrs [3] = '{6'd50, 6'd18, 6'd63};
    logic [63:0]   lits  [3] = '{64'h0, 64'h5555, 64'h0};
    drive_cycle(1'b0, '0, 1'b1, 6'd18, 64'h5555, 4'hF);
    drive_cycle(1'b0, '0, 1'b1, 6'd50, 64'hDEAD, 4'hF);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, addrs[i], 1'b0, '0, '0, '0);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL oor_read %0d: no expected entry", i);
      end else begin
        exp = exp_q.pop_front();
        if (R0_data !== exp || R0_data !== lits[i]) begin
          n_errors++;
          $display("FAIL oor_read addr %0d: got %h, required %h", addrs[i], R0_data, lits[i]);
        end
      end
    end
  endtask

  task automatic test_read_hold();
    logic [63:0] exp;
    drive_cycle(1'b1, 6'd31, 1'b0, '0, '0, '0);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL hold_first_read: no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (R0_data !== exp || R0_data !== 64'h1111_2222_3333_4444) begin
        n_errors++;
        $display("FAIL hold_first_read: got %h, required %h", R0_data, 64'h1111_2222_3333_4444);
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, '0, 1'b1, 6'd31, {$urandom, $urandom}, 4'hF);
      n_checks++;
      if (R0_data !== 64'h1111_2222_3333_4444) begin
        n_errors++;
        $display("FAIL hold cycle %0d: got %h, required %h", k, R0_data, 64'h1111_2222_3333_4444);
      end
    end
    drive_cycle(1'b1, 6'd31, 1'b0, '0, '0, '0);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL hold_reread: no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (R0_data !== exp) begin
        n_errors++;
        $display("FAIL hold_reread: got %h, required %h", R0_data, exp);
      end
    end
  endtask

  task automatic test_collision();
    logic [63:0] exp;
    logic [63:0] lit;
`ifdef MEM_1R1W_BANKED_BYPASS_EN
    lit = 64'h0000_0000_9ABC_DEF0;
`else
    lit = 64'h0;
`endif
    drive_cycle(1'b1, 6'd5, 1'b1, 6'd5, 64'h1234_5678_9ABC_DEF0, 4'b0011);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL collision_read: no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (R0_data !== exp || R0_data !== lit) begin
        n_errors++;
        $display("FAIL collision_read: got %h, required %h", R0_data, lit);
      end
    end
    drive_cycle(1'b1, 6'd5, 1'b0, '0, '0, '0);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL collision_reread: no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (R0_data !== exp || R0_data !== 64'h0000_0000_9ABC_DEF0) begin
        n_errors++;
        $display("FAIL collision_reread: got %h, required %h", R0_data, 64'h0000_0000_9ABC_DEF0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]   exp;
    logic          rd;
    logic          wr;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    for (int k = 0; k < 300; k++) begin
      rd = 1'($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 3) != 0);
      ra = AW'($urandom_range(0, 55));
      wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 55));
      drive_cycle(rd, ra, wr, wa, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      if (rd) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_read %0d: no expected entry", k);
        end else begin
          exp = exp_q.pop_front();
          if (R0_data !== exp) begin
            n_errors++;
            $display("FAIL b2b_read %0d addr %0d: got %h, required %h", k, ra, R0_data, exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [63:0] exp;
    drive_cycle(1'b0, '0, 1'b1, 6'd40, 64'h0123_4567_89AB_CDEF, 4'hF);
    drive_cycle(1'b1, 6'd40, 1'b0, '0, '0, '0);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL mid_pre_read: no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (R0_data !== exp || R0_data !== 64'h0123_4567_89AB_CDEF) begin
        n_errors++;
        $display("FAIL mid_pre_read: got %h, required %h", R0_data, 64'h0123_4567_89AB_CDEF);
      end
    end
    model_clear();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b0, '0, 1'b1, 6'd40, {$urandom, $urandom}, 4'hF);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (init_done !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_clear_init_done cycle %0d: got %b, required 0", k, init_done);
      end
      @(posedge clock);
      @(negedge clock);
    end
    n_checks++;
    if (init_done !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_clear_done_rise: got %b, required 1", init_done);
    end
    model_ready = 1'b1;
    drive_cycle(1'b1, 6'd40, 1'b0, '0, '0, '0);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL mid_post_read: no expected entry");
    end else begin
      exp = exp_q.pop_front();
      if (R0_data !== exp || R0_data !== 64'h0) begin
        n_errors++;
        $display("FAIL mid_post_read: got %h, required 0", R0_data);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_bank_boundary_mask();
    test_out_of_range();
    test_read_hold();
    test_collision();
    test_back_to_back();
    test_reset_mid_clear();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_1r1w_banked.md
# mem_1r1w_banked

Parametrised single-clock 1-read/1-write memory built from power-of-two banks. Adds per-lane write masking, post-reset hardware clearing with a done flag, out-of-range address protection and optional read-during-write forwarding. Serves as a drop-in SRAM wrapper for register files, queues and caches that need one read and one write port per cycle.

## Interface
- DEPTH, 48: total entries, ≥ 1.
- WIDTH, 64: bits per entry.
- BANK_DEPTH, 32: entries per bank; power of two, ≥ 2.
- MASK_GRAN, 16: bits per write-mask lane; WIDTH must be a multiple of it.
- Derived: ADDR_W = max(1, clog2(DEPTH)); NBANKS = ceil(DEPTH/BANK_DEPTH); LANES = WIDTH/MASK_GRAN; ROW_W = log2(BANK_DEPTH).

Ports:
- clock  in  1: single clock, all logic on the rising edge.
- reset  in  1: synchronous, active-high.
- init_done  out  1: 1 once clearing is complete.
- R0_addr  in  ADDR_W: read address.
- R0_en  in  1: read enable.
- R0_data  out  WIDTH: read data, one cycle after the accepted read.
- W0_addr  in  ADDR_W: write address.
- W0_en  in  1: write enable.
- W0_data  in  WIDTH: write data.
- W0_mask  in  LANES: bit i enables bits [i*MASK_GRAN +: MASK_GRAN].

## Operation
- Bank select = addr >> ROW_W. Row = addr[ROW_W-1:0]. An address is in range when addr < DEPTH.
- Init FSM has two states, CLEAR and READY.
  - Reset enters CLEAR with row counter 0. Reset in any state, mid-clear included, restarts from row 0.
  - In CLEAR, each cycle writes all-zero to row `counter` of every bank, then increments the counter.
  - After row BANK_DEPTH-1 is written, the FSM moves to READY. It stays in READY until the next reset.
  - init_done = (state == READY).
- While in CLEAR, R0_en and W0_en are ignored and R0_data is 0.
- Write, when READY, W0_en=1 and W0_addr is in range:
  - Only lanes with W0_mask[i]=1 are updated in the selected bank.
  - W0_mask = 0 writes nothing.
  - An out-of-range write is dropped silently.
- Read, when READY and R0_en=1:
  - Only the selected bank's row is read.
  - The bank index and an in-range flag are registered.
  - R0_data = selected bank output, or 0 if the registered address was out of range.
- Read hold: when R0_en=0, R0_data keeps its last value. The bank index register and bank outputs update only on an accepted read.
- Collision means a same-cycle read and write to the same in-range address. The result is set by MEM_1R1W_BANKED_BYPASS_EN (see Configuration).
- No other cross-port interaction. Reads and writes to different addresses are fully independent.

## Timing
- Reset values: init_done=0, R0_data=0, bank index register=0, in-range flag=0, FSM=CLEAR, counter=0.
- Clear duration: BANK_DEPTH cycles after reset deasserts. init_done rises on the following edge, which is cycle 32 for the defaults.
- Read latency: 1 cycle, registered output.
- Write visibility: a write at edge N is visible to a read issued in cycle N+1, with data returned at N+2.
- The first user operation is accepted in the cycle where init_done=1.

## Configuration
- MEM_1R1W_BANKED_BYPASS_EN defined:
  - On a collision, R0_data (next cycle) = W0_data on masked-in lanes and old contents on masked-out lanes.
  - Implemented with a registered forward of data and mask merged after the bank mux.
- Undefined:
  - On a collision, R0_data returns the old contents on all lanes (read-before-write).
  - No forwarding logic is built.

## Test plan
- **Reset/clear:** assert reset 3 cycles, then release.
  - init_done=0 for 32 cycles, then 1.
  - Reading addresses 0, 31, 32 and 47 returns 0.
  - Writes issued during CLEAR have no effect.
- **Bank boundary and mask:**
  - Write 0x1111_2222_3333_4444 to address 31 and 0xAAAA_BBBB_CCCC_DDDD to address 32, mask 4'hF. Reads return each value exactly, with no cross-bank aliasing.
  - Then write 0xFFFF_FFFF_FFFF_FFFF to address 32 with mask 4'b0101. The read returns 0xAAAA_FFFF_CCCC_FFFF.
- **Out of range:** write 0xDEAD to address 50 (DEPTH=48, ADDR_W=6).
  - Reading address 50 returns 0.
  - Address 18 (50 mod 32, bank 0) is unchanged.
- **Read hold:** read address 31, then drop R0_en for 5 cycles while writing address 31. R0_data stays at the old value until the next R0_en.
- **Collision:** address 5 holds 0x0, and the test writes 0x1234_5678_9ABC_DEF0 with mask 4'b0011 while reading address 5 in the same cycle.
  - With BYPASS_EN: R0_data = 0x0000_0000_9ABC_DEF0.
  - Without BYPASS_EN: R0_data = 0x0.
  - In both builds, a re-read returns 0x0000_0000_9ABC_DEF0.
- **Reset mid-clear:** pulse reset at cycle 10 of CLEAR, after writing address 40 in a prior READY phase.
  - init_done stays 0 for a further 32 cycles.
  - Address 40 then reads 0.
